// File: rtl/note_player.sv
// note_player: single-voice note player.
//
// Latches a note/duration on load_new_note, looks up the frequency step from an
// external ROM (ROM_LAT cycles), then advances a phase accumulator by that step on
// every sample_tick while counting down the duration on beat ticks. A note_done
// pulse is issued one cycle after the final beat. The phase is never cleared
// between notes, so consecutive notes are phase-continuous.
//
// Optional feature macro: NOTE_PLAYER_ARTIC_EN
//   When defined, notes of two or more beats have their gate dropped for the
//   final beat (articulation). Phase and note_done timing are unaffected.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-low reset
//   play_enable    1 = run, 0 = pause (all state frozen, pulses masked)
//   note           note index, 0 = rest
//   duration       length in beats, 0 treated as 1
//   load_new_note  strobe: latch note/duration and start a lookup
//   beat           beat tick
//   sample_tick    request for the next sample phase
//   freq_rom_addr  frequency ROM address (latched note)
//   freq_step_in   frequency ROM data
//   phase          phase accumulator
//   sample_valid   pulses the cycle after phase updates
//   gate           voice audible
//   busy           in LOOKUP or PLAY
//   note_done      pulse at end of note
module note_player #(
    parameter int unsigned PHASE_W = 22,
    parameter int unsigned STEP_W  = 20,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play_enable,
    input  logic [5:0]         note,
    input  logic [5:0]         duration,
    input  logic               load_new_note,
    input  logic               beat,
    input  logic               sample_tick,
    output logic [5:0]         freq_rom_addr,
    input  logic [STEP_W-1:0]  freq_step_in,
    output logic [PHASE_W-1:0] phase,
    output logic               sample_valid,
    output logic               gate,
    output logic               busy,
    output logic               note_done
);

    typedef enum logic [1:0] {StIdle, StLookup, StPlay} state_e;

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   step_q, step_d;
    logic [5:0]           dur_cnt_q, dur_cnt_d;
    logic [1:0]           lat_cnt_q, lat_cnt_d;
    logic [5:0]           note_q, note_d;
    logic                 sample_valid_q, sample_valid_d;
    logic                 note_done_q, note_done_d;
    logic                 gate_q, gate_d;
`ifdef NOTE_PLAYER_ARTIC_EN
    logic                 long_q, long_d;
`endif

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        step_d         = step_q;
        dur_cnt_d      = dur_cnt_q;
        lat_cnt_d      = lat_cnt_q;
        note_d         = note_q;
        gate_d         = gate_q;
        sample_valid_d = 1'b0;
        note_done_d    = 1'b0;
`ifdef NOTE_PLAYER_ARTIC_EN
        long_d         = long_q;
`endif
        if (play_enable) begin
            // A tick in PLAY always uses the current step, even when a new note
            // is being loaded in the same cycle.
            if (state_q == StPlay && sample_tick) begin
                phase_d        = phase_q + step_q;
                sample_valid_d = 1'b1;
            end

            if (load_new_note) begin
                // Restart from any state; a same-cycle beat is dropped.
                note_d    = note;
                dur_cnt_d = (duration == 6'd0) ? 6'd1 : duration;
                lat_cnt_d = 2'(ROM_LAT);
                state_d   = StLookup;
`ifdef NOTE_PLAYER_ARTIC_EN
                long_d    = (duration >= 6'd2);
`endif
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StLookup: begin
                        lat_cnt_d = lat_cnt_q - 2'd1;
                        if (lat_cnt_q <= 2'd1) begin
                            step_d  = (note_q == 6'd0) ? '0 : PHASE_W'(freq_step_in);
                            state_d = StPlay;
                        end
                    end
                    StPlay: begin
                        if (beat) begin
                            dur_cnt_d = dur_cnt_q - 6'd1;
                            if (dur_cnt_q == 6'd1) begin
                                state_d     = StIdle;
                                note_done_d = 1'b1;
                            end
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end

            // Gate follows the current state, hence lags the state by one cycle.
`ifdef NOTE_PLAYER_ARTIC_EN
            gate_d = (state_q == StPlay) && (note_q != 6'd0) &&
                     !(long_q && dur_cnt_q == 6'd1);
`else
            gate_d = (state_q == StPlay) && (note_q != 6'd0);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            phase_q        <= '0;
            step_q         <= '0;
            dur_cnt_q      <= '0;
            lat_cnt_q      <= '0;
            note_q         <= '0;
            sample_valid_q <= 1'b0;
            note_done_q    <= 1'b0;
            gate_q         <= 1'b0;
`ifdef NOTE_PLAYER_ARTIC_EN
            long_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            step_q         <= step_d;
            dur_cnt_q      <= dur_cnt_d;
            lat_cnt_q      <= lat_cnt_d;
            note_q         <= note_d;
            sample_valid_q <= sample_valid_d;
            note_done_q    <= note_done_d;
            gate_q         <= gate_d;
`ifdef NOTE_PLAYER_ARTIC_EN
            long_q         <= long_d;
`endif
        end
    end

    assign freq_rom_addr = note_q;
    assign phase         = phase_q;
    assign gate          = gate_q;
    assign busy          = (state_q != StIdle);
    // Pulses are masked while paused.
    assign sample_valid  = sample_valid_q & play_enable;
    assign note_done     = note_done_q & play_enable;

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

    localparam int unsigned PHASE_W = 22;
    localparam int unsigned STEP_W  = 20;
    localparam int unsigned ROM_LAT = 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               play_enable;
    logic [5:0]         note;
    logic [5:0]         duration;
    logic               load_new_note;
    logic               beat;
    logic               sample_tick;
    logic [5:0]         freq_rom_addr;
    logic [STEP_W-1:0]  freq_step_in;
    logic [PHASE_W-1:0] phase;
    logic               sample_valid;
    logic               gate;
    logic               busy;
    logic               note_done;

    int vectors    = 0;
    int miscompares = 0;

    note_player #(.PHASE_W(PHASE_W), .STEP_W(STEP_W), .ROM_LAT(ROM_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .play_enable  (play_enable),
        .note         (note),
        .duration     (duration),
        .load_new_note(load_new_note),
        .beat         (beat),
        .sample_tick  (sample_tick),
        .freq_rom_addr(freq_rom_addr),
        .freq_step_in (freq_step_in),
        .phase        (phase),
        .sample_valid (sample_valid),
        .gate         (gate),
        .busy         (busy),
        .note_done    (note_done)
    );

    always #5 clk = ~clk;

    // Frequency ROM contents; address 0 holds non-zero data so rests are checked.
    always_comb begin
        case (freq_rom_addr)
            6'd10:   freq_step_in = 20'h01000;
            6'd33:   freq_step_in = 20'hFEC00;
            6'd20:   freq_step_in = 20'h02000;
            6'd7:    freq_step_in = 20'h00300;
            6'd5:    freq_step_in = 20'h00800;
            default: freq_step_in = 20'hABCDE;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic ld, input logic bt, input logic tk);
        load_new_note = ld;
        beat          = bt;
        sample_tick   = tk;
        @(posedge clk);
        #1;
        load_new_note = 1'b0;
        beat          = 1'b0;
        sample_tick   = 1'b0;
    endtask

    task automatic load(input logic [5:0] n, input logic [5:0] d);
        note     = n;
        duration = d;
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; play_enable = 1'b1; note = '0; duration = '0;
        load_new_note = 1'b0; beat = 1'b0; sample_tick = 1'b0;

        // 1. Reset and basic note.
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gate", 32'(gate), 32'h0);
        chk("rst_addr", 32'(freq_rom_addr), 32'h0);
        chk("rst_pulses", {30'h0, sample_valid, note_done}, 32'h0);
        reset = 1'b1;
        load(6'd10, 6'd3);
        chk("t1_addr", 32'(freq_rom_addr), 32'd10);
        chk("t1_busy", 32'(busy), 32'h1);
        cyc(1'b0, 1'b0, 1'b1);  // still in LOOKUP: tick ignored
        chk("t1_lookup_tick", 32'(phase), 32'h0);
        cyc(1'b0, 1'b0, 1'b1);  // ROM_LAT+1 cycles after load: first advance
        chk("t1_first_adv", 32'(phase), 32'h01000);
        chk("t1_sv", 32'(sample_valid), 32'h1);
        chk("t1_gate", 32'(gate), 32'h1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        chk("t1_phase", 32'(phase), 32'h04000);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t1_no_done", 32'(note_done), 32'h0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t1_done", 32'(note_done), 32'h1);
        chk("t1_busy_fall", 32'(busy), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t1_done_pulse", 32'(note_done), 32'h0);
        chk("t1_gate_fall", 32'(gate), 32'h0);

        // 2. Rest with zero duration.
        load(6'd0, 6'd0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b1);
        chk("t2_phase", 32'(phase), 32'h04000);
        chk("t2_gate", 32'(gate), 32'h0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t2_done", 32'(note_done), 32'h1);

        // 3. Wrap-around.
        load(6'd33, 6'd1);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b1);
        chk("t3_preload", 32'(phase), 32'h3FF000);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t3_done", 32'(note_done), 32'h1);
        load(6'd20, 6'd3);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t3_wrap", 32'(phase), 32'h001000);
        chk("t3_sv", 32'(sample_valid), 32'h1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3_sv_once", 32'(sample_valid), 32'h0);

        // 4. Interrupt with same-cycle beat and tick (dur_cnt = 2 at interrupt).
        cyc(1'b0, 1'b1, 1'b0);
        chk("t4_pre_done", 32'(note_done), 32'h0);
        note = 6'd7; duration = 6'd2;
        cyc(1'b1, 1'b1, 1'b1);
        chk("t4_old_step", 32'(phase), 32'h003000);
        chk("t4_sv", 32'(sample_valid), 32'h1);
        chk("t4_no_done", 32'(note_done), 32'h0);
        chk("t4_addr", 32'(freq_rom_addr), 32'd7);
        chk("t4_busy", 32'(busy), 32'h1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t4_new_step", 32'(phase), 32'h003300);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t4_beat1", 32'(note_done), 32'h0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t4_beat2", 32'(note_done), 32'h1);

        // 5a. Pause mid-note.
        load(6'd10, 6'd2);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t5_pre", 32'(phase), 32'h004300);
        play_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, i[0], ~i[0]);
            chk("t5_frozen", {phase, busy, gate, sample_valid, note_done},
                {22'h004300, 4'b1100});
        end
        play_enable = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        chk("t5_resume_phase", 32'(phase), 32'h005300);
        chk("t5_resume_beat", 32'(note_done), 32'h0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t5_resume_done", 32'(note_done), 32'h1);

        // 5b. Reset during PLAY.
        load(6'd10, 6'd5);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t5_play", 32'(gate), 32'h1);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b1);
        chk("t5_rst_all", {phase, freq_rom_addr, busy, gate, sample_valid, note_done},
            32'h0);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        chk("t5_rst_no_done", {30'h0, busy, note_done}, 32'h0);

        // 6. Articulation.
        load(6'd5, 6'd3);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_gate_on", 32'(gate), 32'h1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t6_gate_b1", 32'(gate), 32'h1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
`ifdef NOTE_PLAYER_ARTIC_EN
        chk("t6_gate_b2", 32'(gate), 32'h0);
`else
        chk("t6_gate_b2", 32'(gate), 32'h1);
`endif
        cyc(1'b0, 1'b1, 1'b0);
        chk("t6_done", 32'(note_done), 32'h1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_gate_end", 32'(gate), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Single-voice note player, directly downstream of the song reader.
- Accepts note/duration/new-note strobes and counts duration in beats.
- Fetches the frequency step for each note from an external frequency ROM.
- Advances a phase accumulator on each sample tick; the phase drives the downstream sine reader / codec path.
- Reports end of note back to the sequencing logic.

Parameters:
- PHASE_W, 22, phase accumulator width (bits).
- STEP_W, 20, frequency step width from ROM; must be <= PHASE_W.
- ROM_LAT, 1, frequency ROM read latency in cycles (legal 1..3).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- play_enable  input  1  1 = run; 0 = pause (freeze all state)
- note  input  6  note index; 0 = rest
- duration  input  6  length in beats; 0 treated as 1
- load_new_note  input  1  1-cycle strobe; latch note/duration
- beat  input  1  1-cycle beat tick
- sample_tick  input  1  1-cycle request for next sample phase
- freq_rom_addr  output  6  address to frequency ROM
- freq_step_in  input  STEP_W  ROM data, valid ROM_LAT cycles after address
- phase  output  PHASE_W  current phase accumulator
- sample_valid  output  1  pulses the cycle after phase updates
- gate  output  1  1 = voice audible
- busy  output  1  1 in LOOKUP or PLAY
- note_done  output  1  1-cycle pulse at end of note

Behaviour:
- Reset: reset low at a clk edge clears everything:
  - state = IDLE; phase, step, dur_cnt, lat_cnt, freq_rom_addr = 0.
  - sample_valid, gate, busy, note_done = 0.
  - Applies mid-note too: no note_done pulse is issued.
- States: IDLE, LOOKUP, PLAY.
- Pause: while play_enable = 0, load_new_note, beat and sample_tick are ignored and all registers hold. Outputs hold, except note_done and sample_valid, which are forced to 0.
- IDLE:
  - On load_new_note: latch note, dur_cnt = max(duration, 1), freq_rom_addr = note, lat_cnt = ROM_LAT; go to LOOKUP.
- LOOKUP:
  - lat_cnt decrements each cycle.
  - When lat_cnt reaches 0: step = zero-extended freq_step_in, or step = 0 if note = 0; go to PLAY.
  - beat and sample_tick are ignored in LOOKUP.
- PLAY:
  - sample_tick: phase <= (phase + step) mod 2^PHASE_W; sample_valid = 1 next cycle.
  - beat: dur_cnt decrements. When dur_cnt goes from 1 to 0: note_done pulses next cycle and state returns to IDLE.
  - The phase is not cleared between notes, so consecutive notes stay phase-continuous.
- load_new_note in LOOKUP or PLAY restarts LOOKUP with the new note:
  - The old note is abandoned and no note_done is issued for it.
  - Any same-cycle beat is dropped.
  - Any same-cycle sample_tick is still applied using the old step.
- Same-cycle beat (final) and sample_tick: both are applied, so note_done and sample_valid pulse together.
- Latency:
  - load_new_note to first phase advance: ROM_LAT + 1 cycles minimum.
  - Final beat to note_done: 1 cycle.
- gate = 1 in PLAY with note != 0; otherwise 0. Registered, so it changes 1 cycle after the state change.
- busy = (state != IDLE).

Optional Feature:
- Macro NOTE_PLAYER_ARTIC_EN.
- When defined (articulation): for notes with latched duration >= 2, gate drops to 0 once dur_cnt = 1, i.e. for the final beat.
  - Phase keeps advancing, so note_done timing is unchanged.
  - Notes with duration <= 1 behave as without the macro.
- When undefined: gate follows the base rule only; no extra logic is present.

Test Plan:
1. Reset/basic note:
   - Stimulus: reset low 3 cycles; ROM_LAT = 1; load note = 10, duration = 3, ROM returns 0x01000; 4 sample_ticks, then 3 beats.
   - Required: freq_rom_addr = 10; phase = 0x04000 after the ticks; note_done 1 cycle after 3rd beat; busy falls with it.
2. Rest and zero duration:
   - Stimulus: note = 0, duration = 0; 5 sample_ticks; 1 beat.
   - Required: phase unchanged; gate = 0; note_done after the single beat.
3. Wrap-around:
   - Stimulus: phase preloaded via prior ticks to 0x3FF000; step = 0x02000; 1 tick.
   - Required: phase = 0x001000; sample_valid pulses once.
4. Interrupt and simultaneity:
   - Stimulus: load_new_note during PLAY with dur_cnt = 2, concurrent with beat and sample_tick.
   - Required: old step applied once; beat dropped; no note_done; new lookup to the new address.
5. Pause and reset mid-note:
   - Stimulus: play_enable = 0 for 10 cycles with beats and ticks toggling, then resume; separately, reset low during PLAY.
   - Required: pause freezes phase/dur_cnt with no pulses and resumes exactly; reset zeroes everything with no note_done.
6. Articulation (NOTE_PLAYER_ARTIC_EN):
   - Stimulus: duration = 3, note = 5.
   - Required: gate = 1 for beats 1–2, gate = 0 after the 2nd beat, note_done after the 3rd. Without the macro, gate stays 1 until note_done.
